// File: rtl/phy_rx_unstripe.sv
// Receive un-striper: locks on COM framing symbols and rebuilds 4-byte words across four lanes.
// Optional PHY_RX_ERRCNT_EN adds a saturating alignment-error counter output err_count.
module phy_rx_unstripe #(
    parameter logic [7:0] COM_SYM = 8'hBC,
    parameter int         GAP_MAX = 16
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] Out0,
    output logic [7:0] Out1,
    output logic [7:0] Out2,
    output logic [7:0] Out3,
    output logic       valid0,
    output logic       valid1,
    output logic       valid2,
    output logic       valid3,
    output logic       locked,
`ifdef PHY_RX_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       align_err
);

    // state     | meaning
    // ST_SEARCH | hunting for a COM symbol; data bytes ignored
    // ST_LOCKED | framed; bytes striped round-robin into lanes 0..3

    localparam int GW = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);
    localparam logic [GW-1:0] GAP_SAT  = GW'(GAP_MAX);

    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [GW-1:0] r_gap_cnt;
    logic [7:0]    r_lane0, r_lane1, r_lane2;
    logic [7:0]    r_out0, r_out1, r_out2, r_out3;
    logic          r_valid;
    logic          r_align_err;

    state_t        w_state_nxt;
    logic [1:0]    w_idx_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic          w_is_com;
    logic          w_word_done;
    logic          w_err;
    logic          w_lane_we;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap_cnt;
        w_word_done = 1'b0;
        w_err       = 1'b0;
        w_lane_we   = 1'b0;
        w_is_com    = (data_in == COM_SYM);
        if (r_state == ST_SEARCH) begin
            if (valid_in) begin
                w_gap_nxt = '0;
                if (w_is_com) begin
                    w_state_nxt = ST_LOCKED;
                    w_idx_nxt   = 2'd0;
                end
            end
        end else if (valid_in) begin
            w_gap_nxt = '0;
            if (w_is_com) begin
                // COM at a word boundary is a benign re-alignment
                w_err     = (r_idx != 2'd0);
                w_idx_nxt = 2'd0;
            end else begin
                w_lane_we   = 1'b1;
                w_word_done = (r_idx == 2'd3);
                w_idx_nxt   = r_idx + 2'd1;
            end
        end else if (r_gap_cnt >= GAP_LAST) begin
            w_state_nxt = ST_SEARCH;
            w_idx_nxt   = 2'd0;
            w_gap_nxt   = GAP_SAT;
            w_err       = 1'b1;
        end else begin
            w_gap_nxt = r_gap_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state     <= ST_SEARCH;
            r_idx       <= 2'd0;
            r_gap_cnt   <= '0;
            r_lane0     <= 8'h00;
            r_lane1     <= 8'h00;
            r_lane2     <= 8'h00;
            r_out0      <= 8'h00;
            r_out1      <= 8'h00;
            r_out2      <= 8'h00;
            r_out3      <= 8'h00;
            r_valid     <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_valid     <= w_word_done;
            r_align_err <= w_err;
            if (w_lane_we) begin
                case (r_idx)
                    2'd0:    r_lane0 <= data_in;
                    2'd1:    r_lane1 <= data_in;
                    2'd2:    r_lane2 <= data_in;
                    default: ;
                endcase
            end
            if (w_word_done) begin
                r_out0 <= r_lane0;
                r_out1 <= r_lane1;
                r_out2 <= r_lane2;
                r_out3 <= data_in;
            end
        end
    end

`ifdef PHY_RX_ERRCNT_EN
    logic [7:0] r_err_count;
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_err_count <= 8'h00;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end
    assign err_count = r_err_count;
`endif

    assign Out0      = r_out0;
    assign Out1      = r_out1;
    assign Out2      = r_out2;
    assign Out3      = r_out3;
    assign valid0    = r_valid;
    assign valid1    = r_valid;
    assign valid2    = r_valid;
    assign valid3    = r_valid;
    assign locked    = (r_state == ST_LOCKED);
    assign align_err = r_align_err;

endmodule

// File: tb/tb_phy_rx_unstripe.sv
// Testbench for phy_rx_unstripe: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_phy_rx_unstripe;

    localparam logic [7:0] COM = 8'hBC;
    localparam int GAP_MAX = 16;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic [7:0] Out0, Out1, Out2, Out3;
    logic       valid0, valid1, valid2, valid3;
    logic       locked, align_err;
`ifdef PHY_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    phy_rx_unstripe #(.COM_SYM(COM), .GAP_MAX(GAP_MAX)) dut (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3),
        .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
        .locked(locked),
`ifdef PHY_RX_ERRCNT_EN
        .err_count(err_count),
`endif
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    // Reference model: framing flag, queue of pending bytes, gap counter
    bit         m_locked;
    logic [7:0] m_part[$];
    int         m_gap;
    logic [31:0] m_out;
    bit         m_valid, m_err;
    int         m_errcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic [7:0] d);
        m_valid = 0;
        m_err = 0;
        if (!r) begin
            m_locked = 0; m_part.delete(); m_gap = 0; m_out = '0; m_errcnt = 0;
        end else if (!m_locked) begin
            if (v && d == COM) begin
                m_locked = 1; m_gap = 0; m_part.delete();
            end
        end else if (v) begin
            m_gap = 0;
            if (d == COM) begin
                if (m_part.size() != 0) m_err = 1;
                m_part.delete();
            end else begin
                m_part.push_back(d);
                if (m_part.size() == 4) begin
                    m_out = {m_part[0], m_part[1], m_part[2], m_part[3]};
                    m_valid = 1;
                    m_part.delete();
                end
            end
        end else begin
            m_gap++;
            if (m_gap >= GAP_MAX) begin
                m_locked = 0; m_part.delete(); m_gap = 0; m_err = 1;
            end
        end
        if (m_err && m_errcnt < 255) m_errcnt++;
    endtask

    function automatic logic [63:0] dut_vec();
        return {22'd0, Out0, Out1, Out2, Out3, valid0, valid1, valid2, valid3, locked, align_err};
    endfunction

    function automatic logic [63:0] mk_vec(input logic [31:0] w, input logic v, input logic l, input logic e);
        return {22'd0, w, {4{v}}, l, e};
    endfunction

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        reset_L = r; valid_in = v; data_in = d;
        @(posedge clk);
        model_update(r, v, d);
        #1;
        check("model", dut_vec(), mk_vec(m_out, m_valid, m_locked, m_err));
`ifdef PHY_RX_ERRCNT_EN
        check("err_count_model", {56'd0, err_count}, 64'(m_errcnt));
`endif
    endtask

    typedef struct {
        logic r; logic v; logic [7:0] d;
        logic [31:0] w; logic ev; logic el; logic ee;
    } vec_t;
    vec_t tbl[18];

    int pulses;
    int burst;

    initial begin
        // reset, SEARCH ignores data, lock, word, misaligned COM, recovery, benign COM
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hA1, 32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'hA2, 32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, COM,   32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'h11, 32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h22, 32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'h33, 32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h44, 32'h11223344, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 32'h11223344, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'h11, 32'h11223344, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h22, 32'h11223344, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, COM,   32'h11223344, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 8'h55, 32'h11223344, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 8'h66, 32'h11223344, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 8'h77, 32'h11223344, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 8'h88, 32'h55667788, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, COM,   32'h55667788, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 32'h55667788, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d);
            check($sformatf("table[%0d]", i), dut_vec(),
                  mk_vec(tbl[i].w, tbl[i].ev, tbl[i].el, tbl[i].ee));
        end

        // bubbles mid-word shorter than the timeout keep the word intact
        step(1, 1, 8'h11);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h00);
        step(1, 1, 8'h22);
        step(1, 1, 8'h33);
        step(1, 1, 8'h44);
        check("gap_word", dut_vec(), mk_vec(32'h11223344, 1'b1, 1'b1, 1'b0));

        // gap timeout: 15 idle cycles still locked, 16th drops lock
        step(1, 1, 8'h11);
        for (int i = 0; i < 15; i++) step(1, 0, 8'h00);
        check("gap15_locked", dut_vec(), mk_vec(32'h11223344, 1'b0, 1'b1, 1'b0));
        step(1, 0, 8'h00);
        check("gap16_timeout", dut_vec(), mk_vec(32'h11223344, 1'b0, 1'b0, 1'b1));
        step(1, 1, 8'h99);
        check("post_timeout", dut_vec(), mk_vec(32'h11223344, 1'b0, 1'b0, 1'b0));

        // reset mid-word discards the partial word
        step(1, 1, COM);
        step(1, 1, 8'hAA);
        step(1, 1, 8'hBB);
        step(0, 1, 8'hCC);
        check("reset_mid", dut_vec(), mk_vec(32'h0, 1'b0, 1'b0, 1'b0));
        pulses = 0;
        step(1, 1, COM);
        step(1, 1, 8'hDE); pulses += valid0;
        step(1, 1, 8'hAD); pulses += valid0;
        step(1, 1, 8'hBE); pulses += valid0;
        step(1, 1, 8'hEF); pulses += valid0;
        step(1, 0, 8'h00); pulses += valid0;
        check("reset_word", dut_vec(), mk_vec(32'hDEADBEEF, 1'b0, 1'b1, 1'b0));
        check("reset_pulses", 64'(pulses), 64'd1);

        // three misaligned COMs
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 8'h11);
            step(1, 1, COM);
            check("misalign_err", {63'd0, align_err}, 64'd1);
        end
`ifdef PHY_RX_ERRCNT_EN
        check("err_count_3", {56'd0, err_count}, 64'd3);
`endif

        // random traffic against the model
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic v, r;
            logic [7:0] d;
            r = ($urandom_range(0, 599) != 0);
            if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(1, 20);
            if (burst > 0) begin
                v = 1'b0;
                burst--;
            end else begin
                v = ($urandom_range(0, 9) != 0);
            end
            d = ($urandom_range(0, 7) == 0) ? COM : 8'($urandom);
            step(r, v, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
